adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one 32-bit adder between NUM_REQ requesters, for example the PC+4 incrementer, the branch-target calculator and the load/store address generator.
- Grants are round-robin; each requester uses a valid/ready handshake.
- The sum is registered into a single output slot that carries the requester ID and supports backpressure.
- Sits between the CPU datapath requesters and the shared adder; the adder itself stays combinational inside this block.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 32, operand and result width.
- ID_W, derived localparam = max(1, clog2(NUM_REQ)); width of the requester ID.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*DATA_W  flattened operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  flattened operand B, same packing.
- req_ready  out  NUM_REQ  one-hot grant; request i is accepted when req_valid[i] && req_ready[i].
- out_valid  out  1  result slot holds a valid sum.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  DATA_W  a+b modulo 2^DATA_W.
- out_id  out  ID_W  index of the requester that produced out_data.
- out_ovf  out  1  signed overflow of the sum (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_id=0, out_ovf=0, rr_ptr=0.
  - req_ready is combinational; it is 0 during reset because the slot is treated as not free.
- Slot free condition: slot_free = !out_valid || out_ready.
- Grant: when slot_free, the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ, gets req_ready[i]=1.
  - All other req_ready bits are 0.
  - When !slot_free, req_ready is all 0.
- req_ready may depend combinationally on req_valid and out_ready. Requesters must not make req_valid depend on req_ready.
- Accept edge:
  - out_data <= a_g + b_g, with the carry out dropped (wrap-around: 0xFFFFFFFF+1 = 0).
  - out_id <= g, out_valid <= 1, rr_ptr <= (g+1) mod NUM_REQ.
- Latency: exactly one cycle from accept to out_valid. Throughput is one sum per cycle when out_ready is held at 1.
- Drain without new accept (out_valid && out_ready, no req_valid): out_valid <= 0. out_data and out_id keep their stale values.
- Simultaneous drain and accept: the new result replaces the old one in the same edge, with no bubble.
- Backpressure (out_valid && !out_ready): out_data, out_id, out_ovf and out_valid hold stable, and no grant is issued.
- No requests: rr_ptr is unchanged.
- A requester may drop req_valid without being granted; nothing is latched for it.
- Reset asserted mid-operation: the pending result is discarded immediately (asynchronously) and rr_ptr returns to 0.
- NUM_REQ not a power of two: rr_ptr wraps from NUM_REQ-1 to 0, never reaching unused codes.

Optional Feature:
- Macro: ADDER_SHARE_OVF_EN.
- Defined: out_ovf is registered with out_data as (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), for use by the ALU add-trap path.
- Undefined: out_ovf is tied to 0, and no overflow logic or flop is synthesised. The port still exists so the interface is identical in both builds.

Decomposition:
- Package adder_share_pkg:
  - default constants ADDER_DATA_W=32 and ADDER_NUM_REQ=3;
  - function clog2_min1.
- Sub-module rr_arbiter: parameter N. Inputs are the request vector, the pointer and an enable (slot_free). Output is the one-hot grant plus the binary index.
- The top level holds rr_ptr, the operand mux, the adder, the output register and the optional overflow logic.

Test Plan:
1. Reset then single request: req_valid=001, a=5, b=7 → req_ready=001 in the same cycle; next cycle out_valid=1, out_data=12, out_id=0; rr_ptr=1.
2. Contention with NUM_REQ=3 and req_valid held at 111, out_ready=1 → grants rotate 0,1,2,0,1,2; one result per cycle; out_id follows the same sequence.
3. Backpressure: result pending, out_ready=0 for 3 cycles, req_valid=010 → req_ready=000 and outputs stable for 3 cycles. When out_ready rises, req1 is granted in that cycle and the new result follows the next cycle with no bubble.
4. Wrap and overflow: a=0x7FFFFFFF, b=1 → out_data=0x80000000, out_ovf=1 with the macro and 0 without it. a=0xFFFFFFFF, b=1 → out_data=0, out_ovf=0.
5. Async reset mid-operation: rst_n dropped between edges while out_valid=1 → out_valid=0 immediately. After release, the first grant goes to the lowest-index valid requester.
6. Skip of idle requesters: rr_ptr=1, req_valid=001 → req0 is granted (wrap-around search) and rr_ptr becomes 1.

Source files
------------

// File: rtl/adder_share_pkg.sv
// ============================================================================
// Module : adder_share_pkg
// Brief  : Shared constants and helpers for the shared-adder arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_share_pkg;

    localparam int ADDER_DATA_W  = 32;
    localparam int ADDER_NUM_REQ = 3;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < n) r = k + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_share_arbiter_rr.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin one-hot grant, searching upward from ptr_i modulo N.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int N  = ADDER_NUM_REQ,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW:0] w_j;
    logic        w_found;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < N; k++) begin
            w_j = {1'b0, ptr_i} + (IW+1)'(k);
            if (w_j >= (IW+1)'(N)) w_j = w_j - (IW+1)'(N);
            if (!w_found && req_i[w_j[IW-1:0]]) begin
                w_found              = 1'b1;
                gnt_o[w_j[IW-1:0]]   = 1'b1;
                idx_o                = w_j[IW-1:0];
            end
        end
        if (!en_i) gnt_o = '0;
        any_o = w_found && en_i;
    end

endmodule

`default_nettype wire

// File: rtl/adder_share_arbiter.sv
// ============================================================================
// Module : adder_share_arbiter
// Brief  : One 32-bit adder shared round-robin by NUM_REQ requesters, with a
//          single registered result slot. Macro ADDER_SHARE_OVF_EN enables
//          the registered signed-overflow flag on out_ovf.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = ADDER_NUM_REQ,
    parameter int DATA_W  = ADDER_DATA_W,
    localparam int ID_W   = clog2_min1(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    output logic                      out_ovf
);

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic [ID_W-1:0]     out_id_q,    out_id_d;
    logic [ID_W-1:0]     rr_ptr_q,    rr_ptr_d;

    logic                w_slot_free;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]     w_gnt_idx;
    logic                w_gnt_any;
    logic [DATA_W-1:0]   w_a_g, w_b_g, w_sum;

    // Reset gates the grant so nothing is accepted while rst_n is low.
    assign w_slot_free = rst_n && (!out_valid_q || out_ready);

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .en_i  (w_slot_free),
        .gnt_o (w_gnt),
        .idx_o (w_gnt_idx),
        .any_o (w_gnt_any)
    );

    assign req_ready = w_gnt;

    always_comb begin
        w_a_g = '0;
        w_b_g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_a_g = req_a[i*DATA_W +: DATA_W];
                w_b_g = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_sum = w_a_g + w_b_g;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (w_gnt_any) begin
            out_valid_d = 1'b1;
            out_data_d  = w_sum;
            out_id_d    = w_gnt_idx;
            rr_ptr_d    = (w_gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + ID_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

`ifdef ADDER_SHARE_OVF_EN
    logic out_ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf_q <= 1'b0;
        end else if (w_gnt_any) begin
            out_ovf_q <= (w_a_g[DATA_W-1] == w_b_g[DATA_W-1]) &&
                         (w_sum[DATA_W-1] != w_a_g[DATA_W-1]);
        end
    end

    assign out_ovf = out_ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
// ============================================================================
// Module : tb_adder_share_arbiter
// Brief  : Directed table-driven bench for adder_share_arbiter (NUM_REQ=3).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_share_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
`ifdef ADDER_SHARE_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0][DW-1:0] a_arr, b_arr;
    logic [N*DW-1:0]   req_a, req_b;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_id;
    logic              out_ovf;

    assign req_a = a_arr;
    assign req_b = b_arr;

    adder_share_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]         valid;
        logic [N-1:0][DW-1:0] a;
        logic [N-1:0][DW-1:0] b;
        logic                 ordy;
        logic [N-1:0]         exp_ready;
        logic                 exp_valid;
        logic [DW-1:0]        exp_data;
        logic [1:0]           exp_id;
        logic                 exp_ovf;
    } row_t;

    localparam int NROWS = 12;
    row_t tbl [NROWS];

    int total;
    int bad;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0][DW-1:0] a,
                         input logic [N-1:0][DW-1:0] b, input logic ordy);
        req_valid = v;
        a_arr     = a;
        b_arr     = b;
        out_ready = ordy;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic [1:0] id, input logic ovf);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".data"},  64'(out_data),  64'(d));
        chk({tag, ".id"},    64'(out_id),    64'(id));
        chk({tag, ".ovf"},   64'(out_ovf),   64'(ovf));
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Cycle-by-cycle rows starting right after reset (rr_ptr = 0).
        tbl[0]  = '{3'b001, {32'd0, 32'd0, 32'd5}, {32'd0, 32'd0, 32'd7}, 1'b1,
                    3'b001, 1'b1, 32'd12, 2'd0, 1'b0};
        tbl[1]  = '{3'b111, {32'd30, 32'd20, 32'd10}, {32'd3, 32'd2, 32'd1}, 1'b1,
                    3'b010, 1'b1, 32'd22, 2'd1, 1'b0};
        tbl[2]  = '{3'b111, {32'd30, 32'd20, 32'd10}, {32'd3, 32'd2, 32'd1}, 1'b1,
                    3'b100, 1'b1, 32'd33, 2'd2, 1'b0};
        tbl[3]  = '{3'b111, {32'd30, 32'd20, 32'd10}, {32'd3, 32'd2, 32'd1}, 1'b1,
                    3'b001, 1'b1, 32'd11, 2'd0, 1'b0};
        tbl[4]  = '{3'b111, {32'd30, 32'd20, 32'd10}, {32'd3, 32'd2, 32'd1}, 1'b1,
                    3'b010, 1'b1, 32'd22, 2'd1, 1'b0};
        tbl[5]  = '{3'b111, {32'd30, 32'd20, 32'd10}, {32'd3, 32'd2, 32'd1}, 1'b1,
                    3'b100, 1'b1, 32'd33, 2'd2, 1'b0};
        tbl[6]  = '{3'b001, {32'd0, 32'd0, 32'd5}, {32'd0, 32'd0, 32'd7}, 1'b1,
                    3'b001, 1'b1, 32'd12, 2'd0, 1'b0};
        // rr_ptr is 1 here: idle requesters are skipped and req0 wins by wrap.
        tbl[7]  = '{3'b001, {32'd0, 32'd0, 32'h7FFF_FFFF}, {32'd0, 32'd0, 32'd1}, 1'b1,
                    3'b001, 1'b1, 32'h8000_0000, 2'd0, 1'b1};
        tbl[8]  = '{3'b100, {32'hFFFF_FFFF, 32'd0, 32'd0}, {32'd1, 32'd0, 32'd0}, 1'b1,
                    3'b100, 1'b1, 32'd0, 2'd2, 1'b0};
        tbl[9]  = '{3'b000, {32'd9, 32'd9, 32'd9}, {32'd9, 32'd9, 32'd9}, 1'b1,
                    3'b000, 1'b0, 32'd0, 2'd2, 1'b0};
        tbl[10] = '{3'b010, {32'd0, 32'h8000_0000, 32'd0}, {32'd0, 32'h8000_0000, 32'd0}, 1'b1,
                    3'b010, 1'b1, 32'd0, 2'd1, 1'b1};
        tbl[11] = '{3'b011, {32'd0, 32'd50, 32'd100}, {32'd0, 32'd60, 32'd200}, 1'b1,
                    3'b001, 1'b1, 32'd300, 2'd0, 1'b0};

        // Reset state: req_ready stays low even with every request raised.
        rst_n = 1'b0;
        drive(3'b111, '0, '0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ready", 64'(req_ready), 64'd0);
        chk_out("reset", 1'b0, 32'd0, 2'd0, 1'b0);
        drive('0, '0, '0, 1'b1);
        rst_n = 1'b1;

        for (int r = 0; r < NROWS; r++) begin
            drive(tbl[r].valid, tbl[r].a, tbl[r].b, tbl[r].ordy);
            #1;
            chk($sformatf("row%0d.ready", r), 64'(req_ready), 64'(tbl[r].exp_ready));
            @(posedge clk);
            #1;
            chk_out($sformatf("row%0d", r), tbl[r].exp_valid, tbl[r].exp_data,
                    tbl[r].exp_id, tbl[r].exp_ovf & OVF_ON);
        end

        // Backpressure: rr_ptr=1, load a result from req0 then stall 3 cycles.
        drive(3'b001, {32'd0, 32'd0, 32'd1}, {32'd0, 32'd0, 32'd2}, 1'b1);
        @(posedge clk);
        #1;
        chk_out("bp.load", 1'b1, 32'd3, 2'd0, 1'b0);
        drive(3'b010, {32'd0, 32'd40, 32'd0}, {32'd0, 32'd2, 32'd0}, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp.stall%0d.ready", c), 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
            chk_out($sformatf("bp.stall%0d", c), 1'b1, 32'd3, 2'd0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release.ready", 64'(req_ready), 64'(3'b010));
        @(posedge clk);
        #1;
        chk_out("bp.release", 1'b1, 32'd42, 2'd1, 1'b0);
        drive(3'b000, '0, '0, 1'b1);
        @(posedge clk);
        #1;
        chk("bp.drain.valid", 64'(out_valid), 64'd0);
        chk("bp.drain.data", 64'(out_data), 64'd42);

        // Asynchronous reset while a result is pending (rr_ptr is 2 here).
        drive(3'b100, {32'd1, 32'd0, 32'd0}, {32'd1, 32'd0, 32'd0}, 1'b0);
        @(posedge clk);
        #1;
        chk_out("ar.load", 1'b1, 32'd2, 2'd2, 1'b0);
        drive(3'b111, '0, '0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("ar.async", 1'b0, 32'd0, 2'd0, 1'b0);
        chk("ar.async.ready", 64'(req_ready), 64'd0);
        #2;
        rst_n = 1'b1;
        drive(3'b110, {32'd7, 32'd8, 32'd0}, {32'd1, 32'd2, 32'd0}, 1'b1);
        #1;
        chk("ar.after.ready", 64'(req_ready), 64'(3'b010));
        @(posedge clk);
        #1;
        chk_out("ar.after", 1'b1, 32'd10, 2'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
